// File: rtl/perceptron_sched_if.sv
// rtl/perceptron_sched_if.sv - requester, config, datapath and response signals of perceptron_sched
interface perceptron_sched_if #(
  parameter int DW = 8
);
  // requester 0 / 1 feature vectors
  logic            req0_valid;
  logic [2*DW-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [2*DW-1:0] req1_data;
  logic            req1_ready;
  // weight configuration port
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic            cfg_ready;
  // perceptron datapath side
  logic [DW-1:0]   pe_in1;
  logic [DW-1:0]   pe_in2;
  logic            pe_start;
  logic            pe_abort;
  logic            pe_done;
  logic [7:0]      pe_class;
  logic            pe_w_we;
  logic [3:0]      pe_w_addr;
  logic [DW-1:0]   pe_w_data;
  // tagged response channel
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [7:0]      rsp_class;
  logic            rsp_err;

  // environment view: drives requests, config, datapath results and rsp_ready
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output cfg_we, cfg_addr, cfg_data,
    output pe_done, pe_class, rsp_ready,
    input  req0_ready, req1_ready, cfg_ready,
    input  pe_in1, pe_in2, pe_start, pe_abort, pe_w_we, pe_w_addr, pe_w_data,
    input  rsp_valid, rsp_id, rsp_class, rsp_err
  );

  // scheduler view
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  cfg_we, cfg_addr, cfg_data,
    input  pe_done, pe_class, rsp_ready,
    output req0_ready, req1_ready, cfg_ready,
    output pe_in1, pe_in2, pe_start, pe_abort, pe_w_we, pe_w_addr, pe_w_data,
    output rsp_valid, rsp_id, rsp_class, rsp_err
  );
endinterface

// File: rtl/perceptron_sched.sv
// rtl/perceptron_sched.sv - round-robin scheduler for a shared bit-serial perceptron datapath
module perceptron_sched #(
  parameter int TIMEOUT = 64,
  parameter int DW      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  perceptron_sched_if.slave   bus
);

  // watchdog only has to count 0..TIMEOUT-1
  localparam int WDW = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_grant;
  logic            r_id;
  logic [DW-1:0]   r_in1;
  logic [DW-1:0]   r_in2;
  logic [7:0]      r_class;
  logic            r_err;
  logic [WDW-1:0]  r_wd;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic            w_timeout;

  // arbitration: config beats requesters; on a tie the requester not served last wins
  assign w_gnt0    = ~bus.cfg_we & bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_gnt1    = ~bus.cfg_we & bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_accept  = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);
  assign w_timeout = (r_state == S_WAIT) & (r_wd == WD_LAST);

  assign bus.pe_in1    = r_in1;
  assign bus.pe_in2    = r_in2;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_class = r_class;
  assign bus.rsp_err   = r_err;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state and handshake/strobe outputs
  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.cfg_ready  = 1'b0;
    bus.pe_w_we    = 1'b0;
    bus.pe_w_addr  = '0;
    bus.pe_w_data  = '0;
    bus.pe_start   = 1'b0;
    bus.pe_abort   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cfg_ready  = bus.cfg_we;
        bus.pe_w_we    = bus.cfg_we;
        if (bus.cfg_we) begin
          bus.pe_w_addr = bus.cfg_addr;
          bus.pe_w_data = bus.cfg_data;
        end
        bus.req0_ready = w_gnt0;
        bus.req1_ready = w_gnt1;
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.pe_start = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the last watchdog cycle still counts as a real result
        if (bus.pe_done) begin
          w_next = S_RESP;
        end else if (w_timeout) begin
          bus.pe_abort = 1'b1;
          w_next       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // operand latch and owner bookkeeping at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1        <= '0;
      r_in2        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_in1        <= w_gnt1 ? bus.req1_data[DW-1:0]    : bus.req0_data[DW-1:0];
      r_in2        <= w_gnt1 ? bus.req1_data[2*DW-1:DW] : bus.req0_data[2*DW-1:DW];
      r_id         <= w_gnt1;
      r_last_grant <= w_gnt1;
    end
  end

  // watchdog: zeroed while issuing so WAIT always starts counting from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_wd <= '0;
    else if (r_state == S_ISSUE) r_wd <= '0;
    else if (r_state == S_WAIT)  r_wd <= r_wd + WDW'(1);
  end

  // response payload: real result or timeout marker, frozen through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_class <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (bus.pe_done) begin
        r_class <= bus.pe_class;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_class <= '0;
        r_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_sched.sv
// tb/tb_perceptron_sched.sv - directed self-checking bench for perceptron_sched
module tb_perceptron_sched;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   busy_bad;
  int   n_start;
  int   n_abort;
  int   bp_bad;

  perceptron_sched_if #(.DW(8)) bus ();

  perceptron_sched #(.TIMEOUT(64), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_busy();
    busy_bad += int'(bus.req0_ready | bus.req1_ready | bus.cfg_ready);
  endtask

  // one full transaction with the requester(s) currently presenting
  task automatic txn(input logic exp_id, input int dly, input logic [7:0] cls, input logic [15:0] data);
    chk("grant_r0", bus.req0_ready, !exp_id);
    chk("grant_r1", bus.req1_ready, exp_id);
    step();
    n_start = 0;
    chk("issue_start", bus.pe_start, 1);
    chk("issue_in1", bus.pe_in1, data[7:0]);
    chk("issue_in2", bus.pe_in2, data[15:8]);
    note_busy();
    step();
    repeat (dly) begin
      n_start += int'(bus.pe_start);
      note_busy();
      step();
    end
    bus.pe_done  = 1'b1;
    bus.pe_class = cls;
    step();
    bus.pe_done  = 1'b0;
    bus.pe_class = 8'h00;
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, exp_id);
    chk("rsp_class", bus.rsp_class, cls);
    chk("rsp_err", bus.rsp_err, 0);
    note_busy();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("extra_start", n_start, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; busy_bad = 0; n_abort = 0; bp_bad = 0; n_start = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.pe_done = 1'b0; bus.pe_class = '0; bus.rsp_ready = 1'b0;

    // reset state
    step();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_pe_start", bus.pe_start, 0);
    chk("rst_pe_abort", bus.pe_abort, 0);
    chk("rst_pe_w_we", bus.pe_w_we, 0);
    chk("rst_pe_in1", bus.pe_in1, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    rst_n = 1'b1;
    step();

    // pe_done outside WAIT is ignored
    bus.pe_done = 1'b1; bus.pe_class = 8'h33;
    step();
    bus.pe_done = 1'b0; bus.pe_class = 8'h00;
    chk("stray_done_rsp", bus.rsp_valid, 0);
    chk("stray_done_start", bus.pe_start, 0);

    // single request: done 20 cycles after start
    bus.req0_valid = 1'b1; bus.req0_data = 16'h0A09;
    #1;
    txn(1'b0, 19, 8'd21, 16'h0A09);
    bus.req0_valid = 1'b0;

    // config priority over a waiting requester
    bus.req1_valid = 1'b1; bus.req1_data = 16'h6655;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd5; bus.cfg_data = 8'h40;
    #1;
    chk("cfg_w_we", bus.pe_w_we, 1);
    chk("cfg_w_addr", bus.pe_w_addr, 5);
    chk("cfg_w_data", bus.pe_w_data, 8'h40);
    chk("cfg_ready", bus.cfg_ready, 1);
    chk("cfg_blocks_r1", bus.req1_ready, 0);
    step();
    bus.cfg_we = 1'b0;
    #1;
    chk("after_cfg_r1_ready", bus.req1_ready, 1);
    step();
    bus.req1_valid = 1'b0;
    chk("cfgtxn_in1", bus.pe_in1, 8'h55);
    step();
    // write arriving while busy is stalled
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd7; bus.cfg_data = 8'h5A;
    #1;
    chk("wait_cfg_ready", bus.cfg_ready, 0);
    chk("wait_pe_w_we", bus.pe_w_we, 0);
    step(); step();
    bus.pe_done = 1'b1; bus.pe_class = 8'd9;
    step();
    bus.pe_done = 1'b0;
    chk("resp_cfg_ready", bus.cfg_ready, 0);
    chk("cfgtxn_rsp_id", bus.rsp_id, 1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("idle_cfg_w_we", bus.pe_w_we, 1);
    chk("idle_cfg_addr", bus.pe_w_addr, 7);
    chk("idle_cfg_ready", bus.cfg_ready, 1);
    step();
    bus.cfg_we = 1'b0;

    // watchdog timeout
    bus.req0_valid = 1'b1; bus.req0_data = 16'hBEEF;
    #1;
    chk("to_ready", bus.req0_ready, 1);
    step();
    bus.req0_valid = 1'b0;
    step();
    for (int i = 1; i <= 63; i++) begin
      n_abort += int'(bus.pe_abort);
      step();
    end
    chk("to_early_abort", n_abort, 0);
    chk("to_abort_64", bus.pe_abort, 1);
    step();
    chk("to_abort_once", bus.pe_abort, 0);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 1);
    chk("to_rsp_class", bus.rsp_class, 0);

    // backpressure: response held, no new acceptance
    bus.req1_valid = 1'b1; bus.req1_data = 16'h1234;
    repeat (10) begin
      #1;
      bp_bad += int'(bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_class !== 8'h00 ||
                     bus.rsp_id !== 1'b0 || bus.req1_ready !== 1'b0 || bus.pe_in1 !== 8'hEF);
      step();
    end
    chk("bp_stable", bp_bad, 0);
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_release", bus.rsp_valid, 0);

    // race: done on the last watchdog cycle wins
    bus.req0_valid = 1'b1; bus.req0_data = 16'h0102;
    step();
    bus.req0_valid = 1'b0;
    step();
    n_abort = 0;
    for (int i = 1; i <= 63; i++) begin
      n_abort += int'(bus.pe_abort);
      step();
    end
    chk("race_early_abort", n_abort, 0);
    bus.pe_done = 1'b1; bus.pe_class = 8'd1;
    #1;
    chk("race_no_abort", bus.pe_abort, 0);
    step();
    bus.pe_done = 1'b0; bus.pe_class = 8'd0;
    chk("race_rsp_err", bus.rsp_err, 0);
    chk("race_rsp_class", bus.rsp_class, 1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // async reset during WAIT
    bus.req1_valid = 1'b1; bus.req1_data = 16'h7788;
    step();
    bus.req1_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("arst_pe_in1", bus.pe_in1, 0);
    chk("arst_pe_in2", bus.pe_in2, 0);
    chk("arst_abort", bus.pe_abort, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_class", bus.rsp_class, 0);
    step();
    rst_n = 1'b1;

    // fairness from reset: both valid continuously, grants 0,1,0,1
    bus.req0_valid = 1'b1; bus.req0_data = 16'h2211;
    bus.req1_valid = 1'b1; bus.req1_data = 16'h4433;
    busy_bad = 0;
    #1;
    txn(1'b0, 2, 8'd10, 16'h2211);
    txn(1'b1, 2, 8'd11, 16'h4433);
    txn(1'b0, 2, 8'd12, 16'h2211);
    txn(1'b1, 2, 8'd13, 16'h4433);
    chk("ready_while_busy", busy_bad, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
